ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave_if.sv | 29 ++
 rtl/ahb_sram_slave.sv | 177 +++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle for the SRAM slave.
//   slave  modport: address/control/write-data in; hreadyout/hresp/hrdata out.
//   master modport: the mirror image, used by whatever drives the bus.
// hready is the bus-level ready (the muxed hreadyout of the selected slave).
interface ahb_sram_slave_if;
  logic        hsel;
  logic [63:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [63:0] hrdata;

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a 64-bit synchronous SRAM.
//   clk, rst        : single rising-edge clock, async active-high reset
//   bus (slave)     : AHB address/data phases, hreadyout/hresp/hrdata back
//   sram_cs/we      : one-cycle access strobe, write enable
//   sram_addr       : 64-bit word address inside the MEM_BYTES window
//   sram_wdata/be   : write data (straight from hwdata) and byte enables
//   sram_rdata      : SRAM read data, valid the cycle after a read strobe
// Every transfer is either a good read, a good write, or a two-cycle ERROR
// response. WAIT_CYCLES adds wait states; reads always cost one more cycle
// than writes because the SRAM returns data one cycle after the strobe.
module ahb_sram_slave #(
  parameter  int MEM_BYTES   = 65536,
  parameter  int WAIT_CYCLES = 0,
  localparam int LOG2        = $clog2(MEM_BYTES),
  // An 8-byte window has no word-address bits; keep a 1-bit port tied to 0.
  localparam int AW          = (LOG2 > 3) ? LOG2 - 3 : 1
) (
  input  logic               clk,
  input  logic               rst,
  ahb_sram_slave_if.slave    bus,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [AW-1:0]      sram_addr,
  output logic [63:0]        sram_wdata,
  output logic [7:0]         sram_be,
  input  logic [63:0]        sram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    be_q, be_d;
  logic          rd_cap_q, rd_cap_d;
  logic [63:0]   hrdata_q, hrdata_d;

  logic          accept;
  logic          align_ok;
  logic          range_ok;
  logic          xfer_err;
  logic [7:0]    be_mask;
  logic          unused_ok;

  // Burst type, protection and lock have no effect on a flat SRAM.
  assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock};

  // Address-phase decode. hsize 4..7 falls into the default arm and is
  // reported through align_ok=0.
  always_comb begin
    accept = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q;
    case (bus.hsize)
      3'd0:    begin align_ok = 1'b1;                   be_mask = 8'h01; end
      3'd1:    begin align_ok = ~bus.haddr[0];          be_mask = 8'h03; end
      3'd2:    begin align_ok = (bus.haddr[1:0] == '0); be_mask = 8'h0F; end
      3'd3:    begin align_ok = (bus.haddr[2:0] == '0); be_mask = 8'hFF; end
      default: begin align_ok = 1'b0;                   be_mask = 8'h00; end
    endcase
    range_ok = ((bus.haddr >> LOG2) == 64'd0);
    xfer_err = ~align_ok | ~range_ok;
  end

  // Next-state / next-output logic. Outputs are derived from the next state
  // so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;

    case (state_q)
      S_WAIT: begin
        // Counter saturates at zero; expiry is the cycle it reads 1.
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (wr_q) begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            we_d    = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:    state_d = S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: ;
    endcase

    // Only IDLE and ERR2 drive hreadyout=1, so an accept can only land there
    // (the last data-phase cycle of the previous transfer, or a quiet bus).
    if (accept) begin
      cnt_d  = 4'(WAIT_CYCLES);
      wr_d   = bus.hwrite;
      addr_d = AW'(bus.haddr >> 3);
      be_d   = be_mask << bus.haddr[2:0];
      if (xfer_err) begin
        state_d = S_ERR1;
      end else begin
        if (WAIT_CYCLES != 0) begin
          state_d = S_WAIT;
        end else if (bus.hwrite) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RD;
        end
        // Reads strobe in the first data-phase cycle; zero-wait writes strobe
        // in their only (final) data-phase cycle.
        if (!bus.hwrite) begin
          cs_d = 1'b1;
        end else if (WAIT_CYCLES == 0) begin
          cs_d = 1'b1;
          we_d = 1'b1;
        end
      end
    end

    hreadyout_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);

    // SRAM data shows up the cycle after the read strobe; hold it from then on.
    rd_cap_d = cs_q & ~we_q;
    hrdata_d = rd_cap_q ? sram_rdata : hrdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 8'h00;
      rd_cap_q    <= 1'b0;
      hrdata_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      rd_cap_q    <= rd_cap_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  // With no wait states the final read cycle is the capture cycle itself,
  // so the fresh SRAM word is forwarded around the holding register.
  assign bus.hrdata    = rd_cap_q ? sram_rdata : hrdata_q;

  assign sram_cs    = cs_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_be    = be_q;
  assign sram_wdata = bus.hwdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
  localparam int MB = 1024;
  localparam int AW = 7;
  localparam int W0 = 0;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cur = 0;
  logic        d_hsel = 1'b0;
  logic [63:0] d_haddr = '0;
  logic        d_hwrite = 1'b0;
  logic [2:0]  d_hsize = '0;
  logic [1:0]  d_htrans = '0;
  logic [63:0] d_hwdata = '0;
  logic [2:0]  d_hburst = '0;
  logic [3:0]  d_hprot = '0;
  logic        d_hlock = 1'b0;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();

  assign bus0.hsel = d_hsel & (cur == 0);
  assign bus1.hsel = d_hsel & (cur == 1);
  assign bus0.haddr = d_haddr;      assign bus1.haddr = d_haddr;
  assign bus0.hwrite = d_hwrite;    assign bus1.hwrite = d_hwrite;
  assign bus0.hsize = d_hsize;      assign bus1.hsize = d_hsize;
  assign bus0.htrans = d_htrans;    assign bus1.htrans = d_htrans;
  assign bus0.hwdata = d_hwdata;    assign bus1.hwdata = d_hwdata;
  assign bus0.hburst = d_hburst;    assign bus1.hburst = d_hburst;
  assign bus0.hprot = d_hprot;      assign bus1.hprot = d_hprot;
  assign bus0.hmastlock = d_hlock;  assign bus1.hmastlock = d_hlock;
  assign bus0.hready = bus0.hreadyout;
  assign bus1.hready = bus1.hreadyout;

  logic          cs0, we0, cs1, we1;
  logic [AW-1:0] a0, a1;
  logic [63:0]   wd0, wd1, rd0, rd1;
  logic [7:0]    be0, be1;

  ahb_sram_slave #(.MEM_BYTES(MB), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .sram_cs(cs0), .sram_we(we0), .sram_addr(a0), .sram_wdata(wd0),
    .sram_be(be0), .sram_rdata(rd0));

  ahb_sram_slave #(.MEM_BYTES(MB), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .sram_cs(cs1), .sram_we(we1), .sram_addr(a1), .sram_wdata(wd1),
    .sram_be(be1), .sram_rdata(rd1));

  // Reference byte image per DUT; the SRAM devices are loaded from it once.
  logic [7:0]  refm [2][MB];
  logic [63:0] mem0 [MB/8];
  logic [63:0] mem1 [MB/8];
  logic        mem_load = 1'b1;

  // Synchronous SRAM devices: byte-masked write, registered read.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < MB/8; w++)
        for (int b = 0; b < 8; b++) begin
          mem0[w][8*b +: 8] <= refm[0][8*w + b];
          mem1[w][8*b +: 8] <= refm[1][8*w + b];
        end
    end else begin
      if (cs0) begin
        if (we0) begin
          for (int b = 0; b < 8; b++) if (be0[b]) mem0[a0][8*b +: 8] <= wd0[8*b +: 8];
        end else rd0 <= mem0[a0];
      end
      if (cs1) begin
        if (we1) begin
          for (int b = 0; b < 8; b++) if (be1[b]) mem1[a1][8*b +: 8] <= wd1[8*b +: 8];
        end else rd1 <= mem1[a1];
      end
    end
  end

  // Observation mux onto the currently selected DUT.
  logic          o_rdy, o_resp, o_cs, o_we;
  logic [63:0]   o_rdata, o_wdata;
  logic [7:0]    o_be;
  logic [AW-1:0] o_addr;
  always_comb begin
    if (cur == 0) begin
      o_rdy = bus0.hreadyout; o_resp = bus0.hresp; o_rdata = bus0.hrdata;
      o_cs = cs0; o_we = we0; o_be = be0; o_addr = a0; o_wdata = wd0;
    end else begin
      o_rdy = bus1.hreadyout; o_resp = bus1.hresp; o_rdata = bus1.hrdata;
      o_cs = cs1; o_we = we1; o_be = be1; o_addr = a1; o_wdata = wd1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, cur, got, exp);
    end
  endtask

  // Called at a negedge in a bus-ready cycle; returns at the negedge of the
  // final data-phase cycle so the next address phase can overlap it.
  task automatic xfer(input bit wr, input logic [63:0] addr, input logic [2:0] size,
                      input logic [63:0] data);
    bit err, done, wfinal;
    int nb, wc, ia, exp_zero, zeros, wstb, rstb, rcyc, cyc, bad_resp;
    logic [7:0]    ebe, gbe;
    logic [63:0]   eword, grd, gwd;
    logic [AW-1:0] gwa, gra;
    wc = (cur == 0) ? W0 : W1;
    zeros = 0; wstb = 0; rstb = 0; rcyc = 0; cyc = 0; bad_resp = 0;
    done = 1'b0; wfinal = 1'b0;
    gbe = 'x; grd = 'x; gwd = 'x; gwa = 'x; gra = 'x;
    nb = 1; err = 1'b1;
    if (size <= 3) begin
      nb = 1 << size;
      err = (addr >= 64'(MB)) || ((addr % 64'(nb)) != 64'd0);
    end
    ia = err ? 0 : int'(addr);
    ebe = 8'(((1 << nb) - 1) << (ia % 8));
    for (int b = 0; b < 8; b++) eword[8*b +: 8] = refm[cur][(ia & ~7) + b];
    exp_zero = err ? 1 : (wr ? wc : wc + 1);

    d_hsel = 1'b1; d_htrans = 2'b10; d_haddr = addr; d_hwrite = wr; d_hsize = size;
    d_hburst = 3'($urandom); d_hprot = 4'($urandom); d_hlock = 1'($urandom);
    @(posedge clk); #1;
    d_hsel = 1'b0; d_htrans = 2'b00; d_hwdata = data;
    while (!done && cyc < 24) begin
      @(negedge clk);
      cyc++;
      if (!o_rdy) zeros++;
      if (o_resp !== err) bad_resp++;
      if (o_cs && o_we) begin wstb++; gbe = o_be; gwa = o_addr; gwd = o_wdata; end
      if (o_cs && !o_we) begin rstb++; rcyc = cyc; gra = o_addr; end
      if (o_rdy) begin done = 1'b1; grd = o_rdata; wfinal = o_cs && o_we; end
    end
    chk("xfer_done", done, 1'b1);
    chk("wait_cycles", zeros, exp_zero);
    chk("hresp", bad_resp, 0);
    if (err) begin
      chk("err_no_strobe", wstb + rstb, 0);
    end else if (wr) begin
      chk("wr_strobes", wstb, 1);
      chk("rd_strobes_in_wr", rstb, 0);
      chk("wr_strobe_final", wfinal, 1'b1);
      chk("wr_be", gbe, ebe);
      chk("wr_addr", gwa, ia / 8);
      chk("wr_data", gwd, data);
      for (int i = 0; i < nb; i++) refm[cur][ia + i] = data[8*((ia % 8) + i) +: 8];
    end else begin
      chk("rd_strobes", rstb, 1);
      chk("wr_strobes_in_rd", wstb, 0);
      chk("rd_strobe_cycle", rcyc, 1);
      chk("rd_addr", gra, ia / 8);
      chk("rd_data", grd, eword);
    end
  endtask

  // IDLE or BUSY transfers with hsel=1: zero-wait OKAY, no SRAM access.
  task automatic idle(input int n, input logic [1:0] tr);
    for (int i = 0; i < n; i++) begin
      d_hsel = 1'b1; d_htrans = tr;
      @(negedge clk);
      chk("idle_rdy", o_rdy, 1'b1);
      chk("idle_resp", o_resp, 1'b0);
      chk("idle_cs", o_cs, 1'b0);
    end
    d_hsel = 1'b0; d_htrans = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] ad;
    logic [2:0]  sz;
    int          r;
    int          wsb;

    for (int i = 0; i < MB; i++) begin
      refm[0][i] = 8'($urandom);
      refm[1][i] = refm[0][i];
    end

    // Reset state on both DUTs.
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cur = k; #1;
      chk("rst_hreadyout", o_rdy, 1'b1);
      chk("rst_hresp", o_resp, 1'b0);
      chk("rst_hrdata", o_rdata, 64'd0);
      chk("rst_cs", o_cs, 1'b0);
      chk("rst_we", o_we, 1'b0);
      chk("rst_be", o_be, 8'h00);
    end
    cur = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait DUT: doubleword write, back-to-back read of the same word.
    xfer(1'b1, 64'h10, 3'd3, 64'h1122334455667788);
    xfer(1'b0, 64'h10, 3'd3, 64'd0);
    chk("b2b_rdata", o_rdata, 64'h1122334455667788);
    // Byte write into lane 3, then read it back.
    d = {$urandom, $urandom};
    d[31:24] = 8'hAB;
    xfer(1'b1, 64'h13, 3'd0, d);
    xfer(1'b0, 64'h10, 3'd3, 64'd0);
    // Misaligned word read, then IDLE, BUSY and an out-of-window read.
    xfer(1'b0, 64'h12, 3'd2, 64'd0);
    idle(1, 2'b00);
    idle(1, 2'b01);
    xfer(1'b0, 64'(MB), 3'd3, 64'd0);
    xfer(1'b0, 64'(MB - 8), 3'd3, 64'd0);
    idle(2, 2'b00);

    // Three-wait DUT.
    cur = 1;
    @(negedge clk);
    xfer(1'b1, 64'h20, 3'd3, 64'hCAFEF00D12345678);
    xfer(1'b0, 64'h20, 3'd3, 64'd0);
    xfer(1'b1, 64'h2A, 3'd1, {$urandom, $urandom});
    xfer(1'b0, 64'h7, 3'd4, 64'd0);
    idle(1, 2'b00);

    // Reset in the middle of a write's wait states: no strobe may escape.
    d_hsel = 1'b1; d_htrans = 2'b10; d_haddr = 64'h40; d_hwrite = 1'b1; d_hsize = 3'd3;
    @(posedge clk); #1;
    d_hsel = 1'b0; d_htrans = 2'b00; d_hwdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    chk("midrst_wait1", o_rdy, 1'b0);
    @(negedge clk);
    chk("midrst_wait2", o_rdy, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rdy_async", o_rdy, 1'b1);
    chk("midrst_cs_async", o_cs, 1'b0);
    wsb = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_cs && o_we) wsb++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_cs && o_we) wsb++;
    end
    chk("midrst_no_wstrobe", wsb, 0);
    xfer(1'b0, 64'h40, 3'd3, 64'd0);
    idle(1, 2'b00);

    // Randomized traffic on each DUT against the byte-image model.
    for (int k = 0; k < 2; k++) begin
      cur = k;
      @(negedge clk);
      for (int t = 0; t < 150; t++) begin
        r  = int'($urandom_range(0, 9));
        sz = (r == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        if (r == 1) ad = ($urandom_range(0, 1) == 0) ? 64'(MB + $urandom_range(0, 255))
                                                    : {$urandom, $urandom};
        else ad = 64'($urandom_range(0, MB - 1));
        if (r > 2 && sz <= 3) ad = ad & ~64'((1 << sz) - 1);
        xfer(1'($urandom), ad, sz, {$urandom, $urandom});
        if ($urandom_range(0, 2) == 0)
          idle(int'($urandom_range(1, 2)), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01);
      end
      idle(1, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
